dff_rr_arbiter: RTL and testbench
=================================

# dff_rr_arbiter

Round-robin arbiter and write sequencer for a shared W-bit DFF register. It lets N requesters share one register. Exactly one requester holds a grant at a time, and only the granted requester's write reaches the register. The block sits between the client ports and the shared register; Q/Qn are the register outputs broadcast to all clients.

## Interface
Parameters:
- N, 4, number of requesters (2..16)
- W, 8, register data width
- MAX_HOLD, 16, maximum grant length in cycles (used only with the timeout feature)

Ports:
- CLK  input  1  clock. All state updates on the rising edge.
- RST  input  1  synchronous, active-high reset. Sampled on the rising CLK edge.
- REQ  input  N  REQ[i] is the request from requester i; held high for the whole ownership period.
- WE  input  N  WE[i] is the write enable; honoured only while i owns the grant.
- D  input  N*W  D[i*W +: W] is requester i's write data.
- GNT  output  N  one-hot grant, or zero when no requester owns the register.
- OWNER  output  $clog2(N)  index of the current grant holder; 0 when GNT==0.
- Q  output  W  shared register value.
- Qn  output  W  bitwise inverse of Q.
- TIMEOUT  output  1  one-cycle pulse when a grant is revoked by the watchdog.

## Operation
State machine (registered): IDLE, GRANT.

Reset values:
- state=IDLE, GNT=0, OWNER=0, Q=0, Qn={W{1}}, TIMEOUT=0
- priority pointer PTR=N-1, so requester 0 wins first
- hold counter=0, lockout mask=0

IDLE:
- If any eligible request (REQ & ~mask) is present, select the first set bit searching PTR+1, PTR+2, … modulo N.
- Go to GRANT with GNT one-hot on that index, OWNER=index, PTR=index.
- No eligible request: stay in IDLE with GNT=0.

GRANT:
- REQ[OWNER]=1: stay. If WE[OWNER]=1, then Q <= D[OWNER], Qn <= ~D[OWNER].
- REQ[OWNER]=0: go to IDLE, GNT=0. A WE in that same cycle is ignored.
- WE from non-owners is always ignored.
- Every grant is followed by exactly one IDLE cycle (bubble) before the next grant, including back-to-back requests.

Other rules:
- Q holds its value whenever no honoured write occurs.
- Qn always equals ~Q.
- Requests changing while in GRANT do not affect the current owner.
- Fairness: with all N requesters active, each receives one grant per N grants.
- RST has priority over every event, including mid-grant and mid-write. The cycle after RST is sampled high shows the reset values, and any write sampled in that cycle is discarded.

## Timing
- Grant latency: REQ rising, sampled at edge k in IDLE, gives GNT valid after edge k; the earliest grant is 1 cycle after the request.
- Write latency: WE sampled at edge k while owned gives Q updated after edge k (1 cycle).
- Release: REQ low sampled at edge k gives GNT=0 after edge k. The next grant appears after edge k+1 at the earliest.
- Hold counter: cleared on entry to GRANT and incremented each cycle spent in GRANT.
- All outputs are registered; there is no combinational path from inputs to outputs.

## Configuration
Macro: DFF_ARB_TIMEOUT_EN.

Defined:
- When the hold counter reaches MAX_HOLD while REQ[OWNER] is still 1, force GRANT→IDLE.
- Pulse TIMEOUT for 1 cycle, coincident with GNT going to 0.
- A write in the revoking cycle is ignored.
- Set mask[OWNER]=1, so that requester is ineligible until it deasserts REQ for at least one sampled cycle. mask[i] clears when REQ[i]=0 is sampled.
- Total grant length is exactly MAX_HOLD cycles.

Undefined:
- No counter and no mask logic. Grants last until released.
- TIMEOUT is tied to 0.

## Test plan
- Reset: assert RST with REQ=4'b1111, WE=4'b1111 → after one edge, GNT=0, Q=8'h00, Qn=8'hFF. Deassert RST → GNT=4'b0001 one cycle later.
- Single write: requester 2 holds REQ, WE=1 for one cycle with D=8'hA5 → GNT=4'b0100, OWNER=2, Q=8'hA5 and Qn=8'h5A one cycle after WE. Drop REQ → GNT=0 next cycle.
- Non-owner write blocked: owner 1 idles with WE=0 while requester 3 drives WE=1, D=8'h3C → Q unchanged.
- Round robin: REQ=4'b1111, each owner releases after 2 cycles → grant order 0,1,2,3,0, with one GNT=0 bubble between grants.
- Reset mid-grant: owner 0 writes 8'h77 in the same cycle RST=1 → Q=8'h00, GNT=0. After RST falls, the first grant goes to requester 0.
- With DFF_ARB_TIMEOUT_EN, MAX_HOLD=4: requester 1 holds REQ indefinitely, requester 2 also requests → GNT[1] high for exactly 4 cycles, TIMEOUT pulses, then a bubble, then GNT=4'b0100. Requester 1 is not re-granted until its REQ drops and rises again.

Source files
------------

// File: rtl/dff_rr_arbiter.sv
// Round-robin arbiter and write sequencer for one shared W-bit register; optional grant watchdog via DFF_ARB_TIMEOUT_EN.
// Grant 1 cycle after REQ in IDLE, write 1 cycle after WE; one IDLE bubble follows every grant; all outputs registered.
module dff_rr_arbiter #(
  parameter int N        = 4,
  parameter int W        = 8,
  parameter int MAX_HOLD = 16
) (
  input  logic                 CLK,
  input  logic                 RST,
  input  logic [N-1:0]         REQ,
  input  logic [N-1:0]         WE,
  input  logic [N*W-1:0]       D,
  output logic [N-1:0]         GNT,
  output logic [$clog2(N)-1:0] OWNER,
  output logic [W-1:0]         Q,
  output logic [W-1:0]         Qn,
  output logic                 TIMEOUT
);

  localparam int OW = $clog2(N);

  typedef enum logic {
    S_IDLE  = 1'b0,
    S_GRANT = 1'b1
  } state_t;

  state_t         r_state;
  logic [N-1:0]   r_gnt;
  logic [OW-1:0]  r_owner;
  logic [OW-1:0]  r_ptr;
  logic [W-1:0]   r_q;
  logic [W-1:0]   r_qn;

  logic [N-1:0]   w_elig;
  logic           w_found;
  logic [OW-1:0]  w_pick;
  logic [OW:0]    w_sum;
  logic           w_req_own;
  logic           w_we_own;
  logic [W-1:0]   w_d_own;
  logic           w_revoke;
  logic           w_enter;

  // Owner-side views of REQ/WE/D, muxed with constant indices so any N is legal.
  always_comb begin
    w_req_own = 1'b0;
    w_we_own  = 1'b0;
    w_d_own   = '0;
    for (int i = 0; i < N; i++) begin
      if (r_owner == OW'(i)) begin
        w_req_own = REQ[i];
        w_we_own  = WE[i];
        w_d_own   = D[i*W +: W];
      end
    end
  end

  // Search PTR+1, PTR+2, ... wrapping; the last candidate is PTR itself.
  always_comb begin
    w_found = 1'b0;
    w_pick  = '0;
    w_sum   = '0;
    for (int off = 1; off <= N; off++) begin
      w_sum = {1'b0, r_ptr} + (OW+1)'(off);
      if (w_sum >= (OW+1)'(N)) begin
        w_sum = w_sum - (OW+1)'(N);
      end
      if (!w_found && w_elig[w_sum[OW-1:0]]) begin
        w_found = 1'b1;
        w_pick  = w_sum[OW-1:0];
      end
    end
  end

  assign w_enter = (r_state == S_IDLE) && w_found;

`ifdef DFF_ARB_TIMEOUT_EN
  localparam int HW = $clog2(MAX_HOLD + 1);

  logic [HW-1:0] r_hold;
  logic [HW-1:0] w_hold_nxt;
  logic [N-1:0]  r_mask;
  logic          r_timeout;

  assign w_hold_nxt = r_hold + HW'(1);
  // Revoke on the edge that would complete the MAX_HOLD-th granted cycle.
  assign w_revoke   = (r_state == S_GRANT) && w_req_own && (w_hold_nxt == HW'(MAX_HOLD));
  assign w_elig     = REQ & ~r_mask;

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_hold    <= '0;
      r_mask    <= '0;
      r_timeout <= 1'b0;
    end else begin
      r_timeout <= w_revoke;
      r_mask    <= (r_mask & REQ) | (w_revoke ? r_gnt : '0);
      if (w_enter) begin
        r_hold <= '0;
      end else if (r_state == S_GRANT) begin
        r_hold <= w_hold_nxt;
      end
    end
  end

  assign TIMEOUT = r_timeout;
`else
  assign w_revoke = 1'b0;
  assign w_elig   = REQ;
  assign TIMEOUT  = 1'b0;
`endif

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_state <= S_IDLE;
      r_gnt   <= '0;
      r_owner <= '0;
      r_ptr   <= OW'(N - 1);
      r_q     <= '0;
      r_qn    <= '1;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_found) begin
            r_state <= S_GRANT;
            r_gnt   <= {{(N-1){1'b0}}, 1'b1} << w_pick;
            r_owner <= w_pick;
            r_ptr   <= w_pick;
          end
        end
        S_GRANT: begin
          if (!w_req_own || w_revoke) begin
            r_state <= S_IDLE;
            r_gnt   <= '0;
            r_owner <= '0;
          end else if (w_we_own) begin
            r_q  <= w_d_own;
            r_qn <= ~w_d_own;
          end
        end
        default: begin
          r_state <= S_IDLE;
          r_gnt   <= '0;
          r_owner <= '0;
        end
      endcase
    end
  end

  assign GNT   = r_gnt;
  assign OWNER = r_owner;
  assign Q     = r_q;
  assign Qn    = r_qn;

endmodule

// File: tb/tb_dff_rr_arbiter.sv
// Directed bench for dff_rr_arbiter (N=4, W=8); exercises the watchdog when DFF_ARB_TIMEOUT_EN is defined.
module tb_dff_rr_arbiter;

  localparam int N = 4;
  localparam int W = 8;
`ifdef DFF_ARB_TIMEOUT_EN
  localparam int MAX_HOLD = 4;
`else
  localparam int MAX_HOLD = 16;
`endif

  logic           clk = 1'b0;
  logic           rst;
  logic [N-1:0]   req;
  logic [N-1:0]   we;
  logic [N*W-1:0] d;
  logic [N-1:0]   gnt;
  logic [1:0]     owner;
  logic [W-1:0]   q;
  logic [W-1:0]   qn;
  logic           timeout;

  int checks = 0;
  int errors = 0;

  dff_rr_arbiter #(.N(N), .W(W), .MAX_HOLD(MAX_HOLD)) dut (
    .CLK    (clk),
    .RST    (rst),
    .REQ    (req),
    .WE     (we),
    .D      (d),
    .GNT    (gnt),
    .OWNER  (owner),
    .Q      (q),
    .Qn     (qn),
    .TIMEOUT(timeout)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  initial begin
    logic [3:0] one;
    rst = 1'b1;
    req = 4'hF;
    we  = 4'hF;
    d   = 32'hFFFF_FFFF;

    // Reset with every request and write asserted
    step();
    chk("reset_gnt",     32'(gnt),     32'h0);
    chk("reset_owner",   32'(owner),   32'h0);
    chk("reset_q",       32'(q),       32'h00);
    chk("reset_qn",      32'(qn),      32'hFF);
    chk("reset_timeout", 32'(timeout), 32'h0);

    rst = 1'b0;
    step();
    chk("first_gnt",   32'(gnt),   32'h1);
    chk("first_owner", 32'(owner), 32'h0);

    // Release with WE still high: the write in the release cycle is dropped
    req = 4'h0;
    step();
    chk("release_gnt", 32'(gnt), 32'h0);
    chk("release_q",   32'(q),   32'h00);

    // Single write by requester 2
    we  = 4'h0;
    req = 4'b0100;
    step();
    chk("wr_gnt",   32'(gnt),   32'h4);
    chk("wr_owner", 32'(owner), 32'h2);
    we = 4'b0100;
    d[23:16] = 8'hA5;
    step();
    chk("wr_q",     32'(q),   32'hA5);
    chk("wr_qn",    32'(qn),  32'h5A);
    chk("wr_held",  32'(gnt), 32'h4);
    req = 4'h0;
    d[23:16] = 8'h11;
    step();
    chk("wr_rel_gnt", 32'(gnt), 32'h0);
    chk("wr_rel_q",   32'(q),   32'hA5);

    // Non-owner write blocked; a new request does not disturb the owner
    we  = 4'h0;
    req = 4'b0010;
    step();
    chk("nw_gnt", 32'(gnt), 32'h2);
    req = 4'b1010;
    we  = 4'b1000;
    d[31:24] = 8'h3C;
    step();
    chk("nw_q",     32'(q),   32'hA5);
    chk("nw_owner", 32'(gnt), 32'h2);
    req = 4'h0;
    we  = 4'h0;
    step();
    chk("nw_rel", 32'(gnt), 32'h0);

    // Round robin with all requesting, each owner holds 2 cycles
    rst = 1'b1;
    step();
    rst = 1'b0;
    req = 4'hF;
    for (int g = 0; g < 5; g++) begin
      one = 4'b0001 << (g % 4);
      step();
      chk($sformatf("rr%0d_gnt", g),   32'(gnt),   32'(one));
      chk($sformatf("rr%0d_owner", g), 32'(owner), 32'(g % 4));
      step();
      chk($sformatf("rr%0d_hold", g),  32'(gnt),   32'(one));
      req = 4'hF & ~one;
      step();
      chk($sformatf("rr%0d_bubble", g), 32'(gnt), 32'h0);
      req = 4'hF;
    end

    // Reset mid-grant while the owner writes
    req = 4'b0001;
    step();
    chk("mg_gnt", 32'(gnt), 32'h1);
    we = 4'b0001;
    d[7:0] = 8'h5A;
    step();
    chk("mg_q", 32'(q), 32'h5A);
    d[7:0] = 8'h77;
    rst = 1'b1;
    step();
    chk("mg_rst_q",   32'(q),   32'h00);
    chk("mg_rst_qn",  32'(qn),  32'hFF);
    chk("mg_rst_gnt", 32'(gnt), 32'h0);
    rst = 1'b0;
    req = 4'hF;
    step();
    chk("mg_regrant",  32'(gnt), 32'h1);
    chk("mg_q_after",  32'(q),   32'h00);
    we  = 4'h0;
    req = 4'h0;

`ifdef DFF_ARB_TIMEOUT_EN
    rst = 1'b1;
    step();
    rst = 1'b0;
    req = 4'b0110;
    step();
    chk("to_gnt0", 32'(gnt), 32'h2);
    step();
    chk("to_gnt1",   32'(gnt),     32'h2);
    chk("to_quiet1", 32'(timeout), 32'h0);
    step();
    chk("to_gnt2", 32'(gnt), 32'h2);
    we = 4'b0010;
    d[15:8] = 8'h21;
    step();
    chk("to_gnt3", 32'(gnt), 32'h2);
    chk("to_q3",   32'(q),   32'h21);
    d[15:8] = 8'h42;
    step();
    chk("to_revoke_gnt", 32'(gnt),     32'h0);
    chk("to_pulse",      32'(timeout), 32'h1);
    chk("to_revoke_q",   32'(q),       32'h21);
    we = 4'h0;
    step();
    chk("to_next_gnt", 32'(gnt),     32'h4);
    chk("to_pulse_end", 32'(timeout), 32'h0);
    req = 4'b0010;
    step();
    chk("to_rel2", 32'(gnt), 32'h0);
    step();
    chk("to_masked", 32'(gnt), 32'h0);
    req = 4'h0;
    step();
    chk("to_drop", 32'(gnt), 32'h0);
    req = 4'b0010;
    step();
    chk("to_regrant", 32'(gnt), 32'h2);
`else
    rst = 1'b1;
    step();
    rst = 1'b0;
    req = 4'b0010;
    step();
    for (int c = 0; c < 20; c++) begin
      chk($sformatf("long%0d_gnt", c), 32'({timeout, gnt}), 32'h02);
      step();
    end
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
